io_display_ctrl: RTL and testbench

Memory-mapped display peripheral on the shared 16-bit memory bus, alongside the memory256x16 chips. It decodes a four-word I/O window, holds the digit values and digit-enable/blink state in registers, and drives the `in7..in0` / `turn_on` inputs of SevenSegmentControl. It also provides a free-running 16-bit tick counter, readable and writable by the processor.

---
 rtl/io_display_ctrl_pkg.sv | 29 ++
 rtl/io_display_ctrl_blink_timer.sv | 46 ++++
 rtl/io_display_ctrl.sv | 100 ++++++++++
 tb/tb_io_display_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/io_display_ctrl_pkg.sv
// Shared bus condition codes and display-window register offsets.
// Imported by the display controller and its blink timer.
package io_display_ctrl_pkg;

    typedef enum logic {
        MEM_WR    = 1'b0,
        MEM_NO_WR = 1'b1
    } wr_cond_code_t;

    typedef enum logic {
        MEM_RD    = 1'b0,
        MEM_NO_RD = 1'b1
    } rd_cond_code_t;

    typedef enum logic [1:0] {
        IO_DISP_LO = 2'd0,
        IO_DISP_HI = 2'd1,
        IO_CTRL    = 2'd2,
        IO_TICK    = 2'd3
    } io_disp_reg_t;

    localparam logic [15:0] IO_DISP_BASE = 16'hFFF0;

    // A divider of 1 still needs a one-bit counter.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/io_display_ctrl_blink_timer.sv
// Blink phase generator: phase toggles every DIV cycles while run is high,
// and counter plus phase are held at zero while run is low.
module blink_timer
    import io_display_ctrl_pkg::*;
#(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clock,
    input  logic reset_L,
    input  logic run,
    output logic phase
);

    localparam int unsigned   W    = cnt_width(DIV);
    localparam logic [W-1:0] TERM = W'(DIV - 1);

    logic [W-1:0] bcnt_q, bcnt_d;
    logic         phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!run) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == TERM) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + W'(1'b1);
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/io_display_ctrl.sv
// Memory-mapped seven-segment display peripheral: four-word window holding
// digit values, enable/blink masks and a free-running tick counter.
module io_display_ctrl
    import io_display_ctrl_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = IO_DISP_BASE,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic [15:0]   address,
    inout  wire  [15:0]   data,
    input  wr_cond_code_t we_L,
    input  rd_cond_code_t re_L,
    output logic [3:0]    in7,
    output logic [3:0]    in6,
    output logic [3:0]    in5,
    output logic [3:0]    in4,
    output logic [3:0]    in3,
    output logic [3:0]    in2,
    output logic [3:0]    in1,
    output logic [3:0]    in0,
    output logic [7:0]    turn_on
);

    logic [15:0]  disp_lo_q, disp_lo_d;
    logic [15:0]  disp_hi_q, disp_hi_d;
    logic [15:0]  ctrl_q, ctrl_d;
    logic [15:0]  tick_q, tick_d;
    logic [15:0]  rd_data;
    logic         hit, wr_en, rd_en, run, phase;
    io_disp_reg_t sel;

    assign hit   = (address[15:2] == BASE_ADDR[15:2]);
    assign sel   = io_disp_reg_t'(address[1:0]);
    assign wr_en = hit && (we_L == MEM_WR);
    // Never drive during our own write or while held in reset.
    assign rd_en = hit && (re_L == MEM_RD) && (we_L != MEM_WR) && reset_L;

    always_comb begin
        disp_lo_d = disp_lo_q;
        disp_hi_d = disp_hi_q;
        ctrl_d    = ctrl_q;
        tick_d    = tick_q + 16'd1;
        if (wr_en) begin
            case (sel)
                IO_DISP_LO: disp_lo_d = data;
                IO_DISP_HI: disp_hi_d = data;
                IO_CTRL:    ctrl_d    = data;
                IO_TICK:    tick_d    = data;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            disp_lo_q <= '0;
            disp_hi_q <= '0;
            ctrl_q    <= '0;
            tick_q    <= '0;
        end else begin
            disp_lo_q <= disp_lo_d;
            disp_hi_q <= disp_hi_d;
            ctrl_q    <= ctrl_d;
            tick_q    <= tick_d;
        end
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            IO_DISP_LO: rd_data = disp_lo_q;
            IO_DISP_HI: rd_data = disp_hi_q;
            IO_CTRL:    rd_data = ctrl_q;
            IO_TICK:    rd_data = tick_q;
            default:    rd_data = '0;
        endcase
    end

    assign data = rd_en ? rd_data : 16'bz;

    // Timer starts counting only the edge after blink_mask becomes nonzero,
    // but a write clearing blink_mask zeroes it on that same edge.
    assign run = (ctrl_q[15:8] != 8'h00) && (ctrl_d[15:8] != 8'h00);

    blink_timer #(
        .DIV (BLINK_DIV)
    ) u_blink_timer (
        .clock   (clock),
        .reset_L (reset_L),
        .run     (run),
        .phase   (phase)
    );

    assign turn_on = ctrl_q[7:0] & ~(ctrl_q[15:8] & {8{phase}});
    assign {in3, in2, in1, in0} = disp_lo_q;
    assign {in7, in6, in5, in4} = disp_hi_q;

endmodule

// File: tb/tb_io_display_ctrl.sv
// Directed scoreboard bench for io_display_ctrl with BLINK_DIV = 4.
module tb_io_display_ctrl;
    import io_display_ctrl_pkg::*;

    localparam int K_DATA = 0;
    localparam int K_TURN = 1;
    localparam int K_DIGS = 2;
    localparam int K_BUSZ = 3;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    logic          clock;
    logic          reset_L;
    logic [15:0]   address;
    wire  [15:0]   data;
    wr_cond_code_t we_L;
    rd_cond_code_t re_L;
    logic [3:0]    in7, in6, in5, in4, in3, in2, in1, in0;
    logic [7:0]    turn_on;
    logic          drv;
    logic [15:0]   tb_data;

    chk_t sb[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [7:0] blink_tab [0:9] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF0,
                                    8'hF0, 8'hF0, 8'hF0, 8'hFF, 8'hFF};

    assign data = drv ? tb_data : 16'bz;

    io_display_ctrl #(
        .BASE_ADDR (16'hFFF0),
        .BLINK_DIV (4)
    ) dut (
        .clock   (clock),
        .reset_L (reset_L),
        .address (address),
        .data    (data),
        .we_L    (we_L),
        .re_L    (re_L),
        .in7     (in7),
        .in6     (in6),
        .in5     (in5),
        .in4     (in4),
        .in3     (in3),
        .in2     (in2),
        .in1     (in1),
        .in0     (in0),
        .turn_on (turn_on)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: everything queued during a cycle is compared at the falling edge.
    always @(negedge clock) begin
        while (sb.size() > 0) begin
            chk_t        c;
            logic [31:0] act;
            logic        ok;
            c = sb.pop_front();
            act = '0;
            ok  = 1'b0;
            case (c.kind)
                K_DATA: begin act = {16'h0, data};  ok = (data === c.exp[15:0]); end
                K_TURN: begin act = {24'h0, turn_on}; ok = (turn_on === c.exp[7:0]); end
                K_DIGS: begin
                    act = {in7, in6, in5, in4, in3, in2, in1, in0};
                    ok  = (act === c.exp);
                end
                default: begin act = {16'h0, data}; ok = (data === 16'bz); end
            endcase
            n_chk++;
            if (ok) n_pass++;
            else if (c.kind == K_BUSZ)
                $display("FAIL %s: got %h want zzzz", c.name, act[15:0]);
            else
                $display("FAIL %s: got %h want %h", c.name, act, c.exp);
        end
    end

    task automatic expect_chk(input int kind, input logic [31:0] exp, input string name);
        sb.push_back('{kind, exp, name});
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        we_L = MEM_NO_WR;
        re_L = MEM_NO_RD;
        drv  = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] v);
        we_L    = MEM_WR;
        address = a;
        tb_data = v;
        drv     = 1'b1;
        step();
        idle();
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e, input string name);
        re_L    = MEM_RD;
        address = a;
        expect_chk(K_DATA, {16'h0, e}, name);
        step();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        reset_L = 1'b0;
        address = 16'h0000;
        tb_data = 16'h0000;
        idle();
        repeat (3) @(posedge clock);
        #1;
        reset_L = 1'b1;

        // Reset state, bus idle
        expect_chk(K_TURN, 32'h0, "rst_turn_on");
        expect_chk(K_DIGS, 32'h0, "rst_digits");
        expect_chk(K_BUSZ, 32'h0, "rst_bus_z");
        step();
        rd(16'hFFF0, 16'h0000, "rst_disp_lo");
        rd(16'hFFF1, 16'h0000, "rst_disp_hi");
        rd(16'hFFF2, 16'h0000, "rst_ctrl");
        rd(16'hFFF3, 16'h0004, "tick_early");
        rd(16'hFFF3, 16'h0005, "tick_next");

        // Digit registers
        wr(16'hFFF0, 16'h4321);
        expect_chk(K_DIGS, 32'h0000_4321, "disp_lo_only");
        wr(16'hFFF1, 16'h8765);
        expect_chk(K_DIGS, 32'h8765_4321, "disp_all");
        rd(16'hFFF0, 16'h4321, "disp_lo_rd");
        rd(16'hFFF1, 16'h8765, "disp_hi_rd");

        // Blinking then steady
        wr(16'hFFF2, 16'h0FFF);
        for (int k = 0; k < 10; k++) begin
            expect_chk(K_TURN, {24'h0, blink_tab[k]}, $sformatf("blink_%0d", k));
            step();
        end
        expect_chk(K_TURN, 32'hFF, "blink_10");
        wr(16'hFFF2, 16'h00FF);
        for (int k = 0; k < 6; k++) begin
            expect_chk(K_TURN, 32'hFF, $sformatf("steady_%0d", k));
            step();
        end
        rd(16'hFFF2, 16'h00FF, "ctrl_rd");

        // Tick load and wrap
        wr(16'hFFF3, 16'hFFFE);
        rd(16'hFFF3, 16'hFFFE, "tick_loaded");
        rd(16'hFFF3, 16'hFFFF, "tick_ffff");
        rd(16'hFFF3, 16'h0000, "tick_wrap");
        rd(16'hFFF3, 16'h0001, "tick_after_wrap");

        // Simultaneous read+write is a write only
        we_L    = MEM_WR;
        re_L    = MEM_RD;
        address = 16'hFFF0;
        tb_data = 16'hABCD;
        drv     = 1'b1;
        expect_chk(K_DATA, 32'hABCD, "rw_no_contention");
        step();
        idle();
        expect_chk(K_DIGS, 32'h8765_ABCD, "rw_wrote");
        rd(16'hFFF0, 16'hABCD, "rw_readback");

        // Out-of-window accesses
        wr(16'hFFEF, 16'h1234);
        re_L    = MEM_RD;
        address = 16'hFFF4;
        expect_chk(K_BUSZ, 32'h0, "oow_bus_z");
        expect_chk(K_DIGS, 32'h8765_ABCD, "oow_no_write");
        step();
        idle();

        // Async reset while blinking
        wr(16'hFFF2, 16'h0FFF);
        repeat (4) step();
        expect_chk(K_TURN, 32'hF0, "pre_rst_blink");
        step();
        re_L    = MEM_RD;
        address = 16'hFFF1;
        reset_L = 1'b0;
        expect_chk(K_TURN, 32'h00, "async_rst_turn_on");
        expect_chk(K_BUSZ, 32'h0, "async_rst_bus_z");
        expect_chk(K_DIGS, 32'h0, "async_rst_digits");
        @(negedge clock);
        #1;
        reset_L = 1'b1;
        idle();
        step();
        rd(16'hFFF3, 16'h0001, "tick_after_rst");
        for (int k = 0; k < 5; k++) begin
            expect_chk(K_TURN, 32'h00, $sformatf("post_rst_dark_%0d", k));
            step();
        end
        wr(16'hFFF2, 16'h0FFF);
        for (int k = 0; k < 6; k++) begin
            expect_chk(K_TURN, {24'h0, blink_tab[k]}, $sformatf("reblink_%0d", k));
            step();
        end

        step();
        step();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
            n_chk += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
